hcsr04_medidor: RTL and testbench

- Ultrasonic range-measurement stage driving an HC-SR04 sensor.
- Sits directly upstream of the measurement/transmission control unit: it takes that unit's medir request and returns pronto plus a 3-digit BCD distance in cm for ASCII transmission.
- Generates the trigger pulse, synchronises and times the echo, and converts echo width to rounded, saturating centimetres.

---
 rtl/hcsr04_medidor.sv | 129 ++++++++++++
 tb/tb_hcsr04_medidor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_medidor.sv
// hcsr04_medidor: HC-SR04 ranging stage: trigger pulse, echo timing, rounded saturating BCD centimetres
// Ports: clock, reset (async, active-high)
//        medir     - start request, sampled only while idle
//        echo      - sensor echo, asynchronous to clock
//        trigger   - registered sensor trigger pulse
//        medida    - BCD distance {hundreds, tens, units}
//        pronto    - one-cycle pulse when medida is updated
//        erro      - echo timeout flag (constant 0 unless HCSR04_TIMEOUT_EN)
//        db_estado - current state code
// Optional feature macro: HCSR04_TIMEOUT_EN (echo watchdog and erro state)
module hcsr04_medidor #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CM_CYCLES      = 2941,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [2:0]  db_estado
);
  localparam int TW = $clog2(TRIGGER_CYCLES + 1);
  localparam int CW = $clog2(CM_CYCLES + 1);
  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    PREPARACAO = 3'd1,
    ENVIA      = 3'd2,
    ESPERA     = 3'd3,
    MEDE       = 3'd4,
    ARMAZENA   = 3'd5,
    FINAL      = 3'd6,
    ERRO       = 3'd7
  } state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_trig;
  logic [CW-1:0] r_tick;
  logic [11:0]   r_acc, r_medida;
  logic          r_sync1, r_echo_s, r_echo_d, r_trigger, r_pronto;
  logic          w_rise, w_fall, w_round, w_cm, w_timeout;
  // Saturating BCD increment: 999 sticks, otherwise ripple decimal carries upward
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    if (v == 12'h999) return v;
    if (v[3:0] != 4'd9) return {v[11:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd9) return {v[11:8], v[7:4] + 4'd1, 4'd0};
    return {v[11:8] + 4'd1, 8'h00};
  endfunction
  assign w_rise  = r_echo_s & ~r_echo_d;
  assign w_fall  = ~r_echo_s & r_echo_d;
  assign w_cm    = r_tick == CW'(CM_CYCLES - 1);
  assign w_round = r_tick >= CW'(CM_CYCLES / 2);
`ifdef HCSR04_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wd;
  logic          r_erro;
  assign w_timeout = r_wd == WW'(TIMEOUT_CYCLES - 1);
  assign erro      = r_erro;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wd   <= '0;
      r_erro <= 1'b0;
    end else begin
      r_wd   <= r_state == PREPARACAO ? '0 : (r_state == ESPERA || r_state == MEDE) ? r_wd + 1'b1 : r_wd;
      r_erro <= r_state == PREPARACAO ? 1'b0 : r_state == ERRO ? 1'b1 : r_erro;
    end
`else
  logic w_unused;
  assign w_unused  = TIMEOUT_CYCLES[0];
  assign w_timeout = 1'b0;
  assign erro      = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      INICIAL:    w_next = medir ? PREPARACAO : INICIAL;
      PREPARACAO: w_next = ENVIA;
      ENVIA:      w_next = r_trig == TW'(TRIGGER_CYCLES - 1) ? ESPERA : ENVIA;
      ESPERA:     w_next = w_timeout ? ERRO : w_rise ? MEDE : ESPERA;
      MEDE:       w_next = w_timeout ? ERRO : w_fall ? ARMAZENA : MEDE;
      ARMAZENA:   w_next = FINAL;
      FINAL:      w_next = INICIAL;
`ifdef HCSR04_TIMEOUT_EN
      ERRO:       w_next = FINAL;
`endif
      default:    w_next = INICIAL;
    endcase
  end
  // Outputs are registered from the next state so they are glitch-free and aligned with the state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state   <= INICIAL;
      r_sync1   <= 1'b0;
      r_echo_s  <= 1'b0;
      r_echo_d  <= 1'b0;
      r_trigger <= 1'b0;
      r_pronto  <= 1'b0;
      r_trig    <= '0;
      r_tick    <= '0;
      r_acc     <= '0;
      r_medida  <= '0;
    end else begin
      r_sync1   <= echo;
      r_echo_s  <= r_sync1;
      r_echo_d  <= r_echo_s;
      r_state   <= w_next;
      r_trigger <= w_next == ENVIA;
      r_pronto  <= w_next == FINAL;
      r_trig    <= r_state == PREPARACAO ? '0 : r_state == ENVIA ? r_trig + 1'b1 : r_trig;
      r_tick    <= (r_state == PREPARACAO || (r_state == ESPERA && w_rise)) ? '0 :
                   r_state == MEDE ? (w_cm ? '0 : r_tick + 1'b1) : r_tick;
      r_acc     <= r_state == PREPARACAO ? 12'h000 : (r_state == MEDE && w_cm) ? bcd_inc(r_acc) : r_acc;
      r_medida  <= r_state == ARMAZENA ? (w_round ? bcd_inc(r_acc) : r_acc) :
                   (r_state == ERRO && w_timeout_en()) ? 12'h999 : r_medida;
    end
  function automatic logic w_timeout_en();
`ifdef HCSR04_TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
  assign trigger   = r_trigger;
  assign medida    = r_medida;
  assign pronto    = r_pronto;
  assign db_estado = r_state;
endmodule

// File: tb/tb_hcsr04_medidor.sv
// tb_hcsr04_medidor: table-driven and randomized self-checking bench for hcsr04_medidor
module tb_hcsr04_medidor;
  localparam int TRIG = 10;
  localparam int CM   = 20;
  localparam int TMO  = 5000;
  logic        clock = 1'b0;
  logic        reset, medir, echo;
  logic        trigger, pronto, erro;
  logic [11:0] medida;
  logic [2:0]  db_estado;
  int          checks = 0;
  int          errors = 0;
  int          n_pronto = 0;
  hcsr04_medidor #(.TRIGGER_CYCLES(TRIG), .CM_CYCLES(CM), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .medir(medir), .echo(echo), .trigger(trigger),
    .medida(medida), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (pronto) n_pronto++;
  typedef struct {
    int          w;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[10];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h (%0d) expected 0x%0h (%0d)", name, got, got, exp, exp);
    end
  endtask
  // Distance from the spec's rules: whole cm, round up when remainder >= CM/2, clamp at 999, then BCD
  function automatic logic [11:0] model(input int n);
    int d;
    d = n / CM + ((n % CM) >= CM / 2 ? 1 : 0);
    if (d > 999) d = 999;
    return 12'((d / 100) * 256 + ((d / 10) % 10) * 16 + d % 10);
  endfunction
  task automatic measure(input int n, output logic [11:0] got, output int np, output int ts, output int tl);
    int k, p0;
    p0 = n_pronto;
    medir = 1'b1;
    tick();
    medir = 1'b0;
    k = 1;
    while (!trigger && k < 20) begin tick(); k++; end
    ts = k;
    tl = 0;
    while (trigger && tl < 100) begin tick(); tl++; end
    repeat (3) tick();
    echo = 1'b1;
    repeat (n) tick();
    echo = 1'b0;
    k = 0;
    while (n_pronto == p0 && k < 20) begin tick(); k++; end
    repeat (3) tick();
    got = medida;
    np  = n_pronto - p0;
  endtask
  initial begin
    logic [11:0] got;
    int np, ts, tl, n, k, p0;
    vecs[0] = '{2460, 12'h123};
    vecs[1] = '{110, 12'h006};
    vecs[2] = '{109, 12'h005};
    vecs[3] = '{20100, 12'h999};
    vecs[4] = '{19959, 12'h998};
    vecs[5] = '{20, 12'h001};
    vecs[6] = '{19, 12'h001};
    vecs[7] = '{9, 12'h000};
    vecs[8] = '{10, 12'h001};
    vecs[9] = '{1, 12'h000};
    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    repeat (3) tick();
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_medida", int'(medida), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_estado", int'(db_estado), 0);
    for (int i = 0; i < 10; i++) begin
      measure(vecs[i].w, got, np, ts, tl);
      chk($sformatf("vec%0d_medida", i), int'(got), int'(vecs[i].exp));
      chk($sformatf("vec%0d_pronto", i), np, 1);
      chk($sformatf("vec%0d_trig_start", i), ts, 2);
      chk($sformatf("vec%0d_trig_len", i), tl, TRIG);
      chk($sformatf("vec%0d_erro", i), int'(erro), 0);
    end
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(1, 1500));
      measure(n, got, np, ts, tl);
      chk($sformatf("rand%0d_w%0d_medida", i, n), int'(got), int'(model(n)));
      chk($sformatf("rand%0d_pronto", i), np, 1);
    end
    // Echo already high during trigger, then medir toggled during mede
    p0 = n_pronto;
    medir = 1'b1;
    tick();
    medir = 1'b0;
    k = 0;
    while (!trigger && k < 20) begin tick(); k++; end
    echo = 1'b1;
    k = 0;
    while (trigger && k < 100) begin tick(); k++; end
    repeat (5) tick();
    chk("early_echo_estado", int'(db_estado), 3);
    echo = 1'b0;
    repeat (5) tick();
    chk("early_echo_still_wait", int'(db_estado), 3);
    echo = 1'b1;
    for (int i = 0; i < 110; i++) begin
      medir = ~medir;
      if (i == 50) chk("toggle_in_mede", int'(db_estado), 4);
      tick();
    end
    echo  = 1'b0;
    medir = 1'b0;
    repeat (20) tick();
    chk("toggle_pronto", n_pronto - p0, 1);
    chk("toggle_medida", int'(medida), 12'h006);
    // Asynchronous reset in the middle of mede
    medir = 1'b1;
    tick();
    medir = 1'b0;
    k = 0;
    while (!trigger && k < 20) begin tick(); k++; end
    k = 0;
    while (trigger && k < 100) begin tick(); k++; end
    repeat (3) tick();
    echo = 1'b1;
    repeat (50) tick();
    chk("pre_reset_estado", int'(db_estado), 4);
    reset = 1'b1;
    #1;
    chk("midrst_trigger", int'(trigger), 0);
    chk("midrst_pronto", int'(pronto), 0);
    chk("midrst_medida", int'(medida), 0);
    chk("midrst_estado", int'(db_estado), 0);
    echo = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    measure(2460, got, np, ts, tl);
    chk("after_rst_medida", int'(got), 12'h123);
    chk("after_rst_pronto", np, 1);
    // No echo at all
    p0 = n_pronto;
    medir = 1'b1;
    tick();
    medir = 1'b0;
    k = 0;
    while (!trigger && k < 20) begin tick(); k++; end
    k = 0;
    while (trigger && k < 100) begin tick(); k++; end
`ifdef HCSR04_TIMEOUT_EN
    k = 0;
    while (!pronto && k < 6000) begin tick(); k++; end
    chk("tmo_latency", k, TMO + 1);
    chk("tmo_erro", int'(erro), 1);
    chk("tmo_medida", int'(medida), 12'h999);
    tick();
    chk("tmo_single_pronto", n_pronto - p0, 1);
    chk("tmo_erro_held", int'(erro), 1);
    measure(110, got, np, ts, tl);
    chk("tmo_clear_erro", int'(erro), 0);
    chk("tmo_next_medida", int'(got), 12'h006);
`else
    repeat (TMO + 1000) tick();
    chk("notmo_estado", int'(db_estado), 3);
    chk("notmo_pronto", n_pronto - p0, 0);
    chk("notmo_erro", int'(erro), 0);
    chk("notmo_medida", int'(medida), 12'h123);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
